// File: rtl/ysyx_24070016_lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Holds funct3 size codes, FSM states and the access-size decode.
package ysyx_24070016_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Unsigned load variants exist only for loads; anything unknown is a word.
    function automatic lsu_size_e f3_size(input logic [2:0] f3,
                                          input logic       is_load);
        lsu_size_e sz;
        sz = SZ_W;
        if (f3 == F3_SB || (is_load && f3 == F3_LBU))
            sz = SZ_B;
        else if (f3 == F3_SH || (is_load && f3 == F3_LHU))
            sz = SZ_H;
        return sz;
    endfunction

endpackage

// File: rtl/ysyx_24070016_lsu_extend.sv
// Load data extraction: picks the addressed byte/halfword from the
// returned word and sign- or zero-extends it to 32 bits.
module ysyx_24070016_LSU_extend
    import ysyx_24070016_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_rdata >> {i_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_24070016_lsu.sv
// Load/store unit: one instruction at a time, one memory transaction
// per load/store, all outputs registered.
module ysyx_24070016_lsu
    import ysyx_24070016_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              in_mem_ren,
    input  logic              in_mem_wen,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [4:0]        out_rd,
    output logic              out_rd_wen,
    output logic              out_misalign
);

    lsu_state_e        r_state;
    logic              r_in_ready;
    logic              r_req_valid;
    logic              r_req_wen;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic [3:0]        r_req_wstrb;
    logic              r_resp_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_wb_data;
    logic [4:0]        r_rd;
    logic              r_rd_wen;
    logic              r_misalign;
    logic              r_is_load;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;

    logic              w_is_mem;
    lsu_size_e         w_size;
    logic [1:0]        w_off;
    logic              w_misalign;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ext;

    assign w_is_mem = in_mem_ren | in_mem_wen;
    assign w_size   = f3_size(in_funct3, in_mem_ren);
    assign w_off    = in_alu_result[1:0];

    assign w_misalign = w_is_mem &&
        ((w_size == SZ_H && w_off[0]) ||
         (w_size == SZ_W && w_off != 2'b00));

    // Store lanes: strobe follows the offset, data is replicated per lane.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = '0;
        if (in_mem_wen) begin
            unique case (w_size)
                SZ_B: begin
                    w_wstrb = 4'b0001 << w_off;
                    w_wdata = {4{in_store_data[7:0]}};
                end
                SZ_H: begin
                    w_wstrb = 4'b0011 << w_off;
                    w_wdata = {2{in_store_data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = in_store_data;
                end
            endcase
        end
    end

    ysyx_24070016_LSU_extend u_extend (
        .i_rdata  (mem_resp_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_wen    <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_wstrb  <= 4'b0000;
            r_resp_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_wb_data    <= '0;
            r_rd         <= 5'd0;
            r_rd_wen     <= 1'b0;
            r_misalign   <= 1'b0;
            r_is_load    <= 1'b0;
            r_off        <= 2'b00;
            r_funct3     <= 3'b000;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!r_in_ready) begin
                        r_in_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_is_load  <= in_mem_ren;
                        r_off      <= w_off;
                        r_funct3   <= in_funct3;
                        r_rd       <= in_rd;
                        r_rd_wen   <= in_rd_wen & ~w_misalign;
                        r_misalign <= w_misalign;
                        r_wb_data  <= w_is_mem ? '0 : in_alu_result;
                        if (!w_is_mem || w_misalign) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_req_wen   <= in_mem_wen;
                            r_req_addr  <= {in_alu_result[ADDR_W-1:2], 2'b00};
                            r_req_wstrb <= w_wstrb;
                            r_req_wdata <= w_wdata;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_resp_ready <= 1'b0;
                        if (r_is_load)
                            r_wb_data <= w_ext;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign mem_req_valid  = r_req_valid;
    assign mem_req_wen    = r_req_wen;
    assign mem_req_addr   = r_req_addr;
    assign mem_req_wdata  = r_req_wdata;
    assign mem_req_wstrb  = r_req_wstrb;
    assign mem_resp_ready = r_resp_ready;
    assign out_valid      = r_out_valid;
    assign out_wb_data    = r_wb_data;
    assign out_rd         = r_rd;
    assign out_rd_wen     = r_rd_wen;
    assign out_misalign   = r_misalign;

endmodule

// File: tb/tb_ysyx_24070016_lsu.sv
// Directed bench for the load/store unit: hand-computed vectors,
// inputs driven and outputs sampled on the falling edge.
module tb_ysyx_24070016_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic        in_mem_ren;
    logic        in_mem_wen;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_wb_data;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic        out_misalign;

    int n_vec;
    int n_err;

    ysyx_24070016_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_mem_ren     (in_mem_ren),
        .in_mem_wen     (in_mem_wen),
        .in_funct3      (in_funct3),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_wb_data    (out_wb_data),
        .out_rd         (out_rd),
        .out_rd_wen     (out_rd_wen),
        .out_misalign   (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one instruction at a falling edge; returns one cycle later.
    task automatic accept(input logic [31:0] alu, input logic [31:0] sd,
                          input logic ren, input logic wen,
                          input logic [2:0] f3, input logic [4:0] rd,
                          input logic rdwen);
        in_valid      = 1'b1;
        in_alu_result = alu;
        in_store_data = sd;
        in_mem_ren    = ren;
        in_mem_wen    = wen;
        in_funct3     = f3;
        in_rd         = rd;
        in_rd_wen     = rdwen;
        tick();
        in_valid      = 1'b0;
        in_alu_result = 32'h0;
        in_store_data = 32'h0;
        in_mem_ren    = 1'b0;
        in_mem_wen    = 1'b0;
    endtask

    // Zero-wait memory transaction with full request and result checks.
    task automatic run_mem(input string tag,
                           input logic [31:0] alu, input logic [31:0] sd,
                           input logic ren, input logic wen,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic rdwen, input logic [31:0] rdata,
                           input logic [31:0] e_addr,
                           input logic [3:0] e_strb,
                           input logic [31:0] e_wdata,
                           input logic [31:0] e_wb,
                           input logic e_rdwen);
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        accept(alu, sd, ren, wen, f3, rd, rdwen);
        check({tag, "_req_valid"}, mem_req_valid, 1);
        check({tag, "_req_addr"}, mem_req_addr, e_addr);
        check({tag, "_req_wen"}, mem_req_wen, wen);
        check({tag, "_req_wstrb"}, mem_req_wstrb, e_strb);
        if (wen)
            check({tag, "_req_wdata"}, mem_req_wdata, e_wdata);
        tick();
        check({tag, "_resp_ready"}, mem_resp_ready, 1);
        check({tag, "_req_drop"}, mem_req_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        check({tag, "_out_valid"}, out_valid, 1);
        if (ren)
            check({tag, "_wb"}, out_wb_data, e_wb);
        check({tag, "_rd_wen"}, out_rd_wen, e_rdwen);
        check({tag, "_misalign"}, out_misalign, 0);
        tick();
        check({tag, "_out_clr"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_alu_result  = 32'h0;
        in_store_data  = 32'h0;
        in_mem_ren     = 1'b0;
        in_mem_wen     = 1'b0;
        in_funct3      = 3'b000;
        in_rd          = 5'd0;
        in_rd_wen      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        out_ready      = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_wb", out_wb_data, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);

        // Non-memory pass-through
        out_ready = 1'b1;
        accept(32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        check("alu_out_valid", out_valid, 1);
        check("alu_wb", out_wb_data, 32'h1234_5678);
        check("alu_rd", out_rd, 5);
        check("alu_rd_wen", out_rd_wen, 1);
        check("alu_in_ready", in_ready, 0);
        check("alu_no_req", mem_req_valid, 0);
        tick();
        check("alu_done", out_valid, 0);
        check("alu_ready_back", in_ready, 1);

        run_mem("lb", 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b000, 5'd7,
                1'b1, 32'h80FF_0011, 32'h8000_0000, 4'b0000, 32'h0,
                32'hFFFF_FF80, 1'b1);
        run_mem("lbu", 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b100, 5'd8,
                1'b1, 32'h80FF_0011, 32'h8000_0000, 4'b0000, 32'h0,
                32'h0000_0080, 1'b1);
        run_mem("lh", 32'h8000_0012, 32'h0, 1'b1, 1'b0, 3'b001, 5'd9,
                1'b1, 32'h9ABC_1234, 32'h8000_0010, 4'b0000, 32'h0,
                32'hFFFF_9ABC, 1'b1);
        run_mem("lw", 32'h8000_0020, 32'h0, 1'b1, 1'b0, 3'b010, 5'd10,
                1'b1, 32'hDEAD_BEEF, 32'h8000_0020, 4'b0000, 32'h0,
                32'hDEAD_BEEF, 1'b1);
        run_mem("sh", 32'h8000_0002, 32'hAAAA_BEEF, 1'b0, 1'b1, 3'b001,
                5'd0, 1'b0, 32'h0, 32'h8000_0000, 4'b1100,
                32'hBEEF_BEEF, 32'h0, 1'b0);
        run_mem("sb", 32'h8000_0031, 32'h1234_56A5, 1'b0, 1'b1, 3'b000,
                5'd0, 1'b0, 32'h0, 32'h8000_0030, 4'b0010,
                32'hA5A5_A5A5, 32'h0, 1'b0);
        run_mem("sw", 32'h8000_0044, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010,
                5'd0, 1'b0, 32'h0, 32'h8000_0044, 4'b1111,
                32'hCAFE_F00D, 32'h0, 1'b0);

        // Misaligned word load: straight to DONE, no request
        out_ready = 1'b1;
        accept(32'h8000_0001, 32'h0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1);
        check("mis_out_valid", out_valid, 1);
        check("mis_flag", out_misalign, 1);
        check("mis_wb", out_wb_data, 0);
        check("mis_rd_wen", out_rd_wen, 0);
        check("mis_no_req", mem_req_valid, 0);
        tick();
        check("mis_no_req2", mem_req_valid, 0);
        check("mis_done", out_valid, 0);

        // Stalled LHU: req_ready low 3 cycles, resp 2 late, out_ready low 2
        mem_req_ready = 1'b0;
        out_ready     = 1'b0;
        accept(32'h8000_0006, 32'h0, 1'b1, 1'b0, 3'b101, 5'd12, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("stl_req_v_c%0d", c), mem_req_valid, 1);
            check($sformatf("stl_req_a_c%0d", c), mem_req_addr,
                  32'h8000_0004);
            check($sformatf("stl_req_w_c%0d", c), mem_req_wen, 0);
            check($sformatf("stl_req_s_c%0d", c), mem_req_wstrb, 0);
            if (c == 4)
                mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            check($sformatf("stl_rr_c%0d", c), mem_resp_ready, 1);
            check($sformatf("stl_ov_c%0d", c), out_valid, 0);
            if (c == 7) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 32'hCAFE_1234;
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        for (int c = 8; c <= 10; c++) begin
            check($sformatf("stl_ov_c%0d", c), out_valid, 1);
            check($sformatf("stl_wb_c%0d", c), out_wb_data, 32'h0000_CAFE);
            check($sformatf("stl_rd_c%0d", c), out_rd, 12);
            if (c == 10)
                out_ready = 1'b1;
            tick();
        end
        check("stl_done", out_valid, 0);
        check("stl_ready_back", in_ready, 1);

        // Reset pulse while waiting for the response
        mem_req_ready = 1'b1;
        accept(32'h8000_0008, 32'h0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
        tick();
        check("rw_in_wait", mem_resp_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_resp_ready", mem_resp_ready, 0);
        check("rw_in_ready", in_ready, 0);
        check("rw_out_valid", out_valid, 0);
        check("rw_req_valid", mem_req_valid, 0);
        check("rw_rd", out_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rw_ready_after", in_ready, 1);
        check("rw_idle_resp", mem_resp_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
